// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the ThinPad UART engine: FSM states, the
// memory-mapped addresses the memory module decodes, and status word layout.
package uart_defs;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_WAIT    = 3'd1,
    RD_LOW     = 3'd2,
    WR_WAIT_TX = 3'd3,
    WR_SETUP   = 3'd4,
    WR_LOW     = 3'd5,
    WR_HOLD    = 3'd6,
    WR_DRAIN   = 3'd7
  } state_t;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  localparam int STAT_TX_READY_BIT   = 0;
  localparam int STAT_DATA_READY_BIT = 1;

  function automatic logic [15:0] status_word(input logic data_ready_s,
                                              input logic tx_ready);
    logic [15:0] w;
    w = 16'h0000;
    w[STAT_DATA_READY_BIT] = data_ready_s;
    w[STAT_TX_READY_BIT]   = tx_ready;
    return w;
  endfunction

endpackage

// File: rtl/uart_ctrl_sync_bit.sv
// Multi-flop synchroniser for one asynchronous UART handshake line.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_r;

  // shift chain, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_r <= '0;
    end else begin
      ff_r <= {ff_r[STAGES-2:0], d};
    end
  end

  assign q = ff_r[STAGES-1];

endmodule

// File: rtl/uart_ctrl.sv
// UART transfer engine: turns one-cycle read/write/status requests into
// rdn/wrn bus cycles on ram1 and reports completion with a done pulse.
module uart_ctrl
  import uart_defs::*;
#(
  parameter int RD_LOW_CYC   = 2,
  parameter int WR_SETUP_CYC = 1,
  parameter int WR_LOW_CYC   = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic        req_status,
  input  logic [7:0]  wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        busy,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_oe,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  localparam logic [3:0] RD_CNT    = 4'(RD_LOW_CYC);
  localparam logic [3:0] SETUP_CNT = 4'(WR_SETUP_CYC);
  localparam logic [3:0] WLOW_CNT  = 4'(WR_LOW_CYC);
  // tbre only falls after wrn rises and needs the synchroniser to catch up
  localparam logic [3:0] GUARD_CNT = 4'(SYNC_STAGES + 1);

  logic data_ready_s, tbre_s, tsre_s, tx_ready;
  logic unused_bus_hi;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_dr (.clk(clk), .rst(rst), .d(data_ready), .q(data_ready_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_te (.clk(clk), .rst(rst), .d(tbre),       .q(tbre_s));
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ts (.clk(clk), .rst(rst), .d(tsre),       .q(tsre_s));

  assign tx_ready      = tbre_s & tsre_s;
  assign unused_bus_hi = ^bus_din[15:8];

  state_t      state_r, state_nx;
  logic [3:0]  cnt_r, cnt_nx;
  logic [7:0]  byte_r, byte_nx;
  logic        rdn_nx, wrn_nx, oe_nx, done_nx, busy_nx;
  logic [15:0] rdata_nx, dout_nx;

  // next-state and next-output logic; every output is registered below
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    byte_nx  = byte_r;
    rdn_nx   = rdn;
    wrn_nx   = wrn;
    oe_nx    = bus_oe;
    dout_nx  = bus_dout;
    rdata_nx = rdata;
    done_nx  = 1'b0;
    busy_nx  = busy;
    case (state_r)
      IDLE: begin
        if (req_read) begin
          busy_nx  = 1'b1;
          state_nx = RD_WAIT;
        end else if (req_write) begin
          byte_nx  = wdata;
          busy_nx  = 1'b1;
          state_nx = WR_WAIT_TX;
        end else if (req_status) begin
          rdata_nx = status_word(data_ready_s, tx_ready);
          done_nx  = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      RD_WAIT: begin
        if (data_ready_s) begin
          rdn_nx   = 1'b0;
          cnt_nx   = RD_CNT;
          state_nx = RD_LOW;
        end else begin
          state_nx = RD_WAIT;
        end
      end
      RD_LOW: begin
        if (cnt_r <= 4'd1) begin
          rdata_nx = {8'h00, bus_din[7:0]};
          rdn_nx   = 1'b1;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          cnt_nx   = 4'd0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      WR_WAIT_TX: begin
        if (tx_ready) begin
          oe_nx    = 1'b1;
          dout_nx  = {8'h00, byte_r};
          cnt_nx   = SETUP_CNT;
          state_nx = WR_SETUP;
        end else begin
          state_nx = WR_WAIT_TX;
        end
      end
      WR_SETUP: begin
        if (cnt_r <= 4'd1) begin
          wrn_nx   = 1'b0;
          cnt_nx   = WLOW_CNT;
          state_nx = WR_LOW;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      WR_LOW: begin
        if (cnt_r <= 4'd1) begin
          wrn_nx   = 1'b1;
          cnt_nx   = 4'd0;
          state_nx = WR_HOLD;
        end else begin
          cnt_nx = cnt_r - 4'd1;
        end
      end
      WR_HOLD: begin
        oe_nx    = 1'b0;
        cnt_nx   = GUARD_CNT;
        state_nx = WR_DRAIN;
      end
      WR_DRAIN: begin
        if (cnt_r != 4'd0) begin
          cnt_nx = cnt_r - 4'd1;
        end else if (tbre_s && tsre_s) begin
          rdata_nx = 16'h0000;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          state_nx = WR_DRAIN;
        end
      end
      default: begin
        rdn_nx   = 1'b1;
        wrn_nx   = 1'b1;
        oe_nx    = 1'b0;
        busy_nx  = 1'b0;
        cnt_nx   = 4'd0;
        state_nx = IDLE;
      end
    endcase
  end

  // state, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      byte_r   <= 8'h00;
      rdn      <= 1'b1;
      wrn      <= 1'b1;
      bus_oe   <= 1'b0;
      bus_dout <= 16'h0000;
      rdata    <= 16'h0000;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      byte_r   <= byte_nx;
      rdn      <= rdn_nx;
      wrn      <= wrn_nx;
      bus_oe   <= oe_nx;
      bus_dout <= dout_nx;
      rdata    <= rdata_nx;
      done     <= done_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl with a behavioural UART transmitter model.
module tb_uart_ctrl;

  localparam int RD_LOW_CYC   = 2;
  localparam int WR_SETUP_CYC = 1;
  localparam int WR_LOW_CYC   = 2;
  localparam int SYNC_STAGES  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_read = 1'b0, req_write = 1'b0, req_status = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic [15:0] rdata;
  logic        done, busy;
  logic [15:0] bus_din = 16'h0000;
  logic [15:0] bus_dout;
  logic        bus_oe, rdn, wrn;
  logic        data_ready = 1'b0;
  logic        tbre_cfg = 1'b1, tsre_cfg = 1'b1;
  logic        tbre_mdl = 1'b1, tsre_mdl = 1'b1;
  logic        tbre, tsre;

  assign tbre = tbre_cfg & tbre_mdl;
  assign tsre = tsre_cfg & tsre_mdl;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_wbyte = 8'h00;
  bit          mdl_active = 1'b0;
  int          tbre_lo = 5, tsre_lo = 8;
  int          wrn_falls = 0;

  always #5 clk = ~clk;

  uart_ctrl #(
    .RD_LOW_CYC(RD_LOW_CYC), .WR_SETUP_CYC(WR_SETUP_CYC),
    .WR_LOW_CYC(WR_LOW_CYC), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_status(req_status), .wdata(wdata), .rdata(rdata), .done(done),
    .busy(busy), .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
    .rdn(rdn), .wrn(wrn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // UART transmitter: after a write strobe, tbre drops, then tsre drops
  always begin
    @(posedge wrn);
    if (rst) begin
      #1;
      mdl_active = 1'b1;
      tbre_mdl   = 1'b0;
      repeat (tbre_lo) @(posedge clk);
      tbre_mdl = 1'b1;
      tsre_mdl = 1'b0;
      repeat (tsre_lo) @(posedge clk);
      tsre_mdl   = 1'b1;
      mdl_active = 1'b0;
    end
  end

  int   rd_run = 0, wr_run = 0, oe_lead = 0;
  logic prev_wrn = 1'b1;
  logic [15:0] exp_word;

  // monitor: bus protocol checks and scoreboard pop on every done pulse
  always @(negedge clk) begin
    if (!rst) begin
      rd_run = 0; wr_run = 0; oe_lead = 0; prev_wrn = 1'b1;
    end else begin
      check(rdn || wrn, "strobe_overlap", {rdn, wrn}, 2'b11);
      check(rdn || !bus_oe, "oe_during_read", bus_oe, 1'b0);
      if (!rdn) rd_run++;
      else if (rd_run > 0) begin
        check(rd_run == RD_LOW_CYC, "rdn_low_len", rd_run, RD_LOW_CYC);
        rd_run = 0;
      end
      if (!wrn && prev_wrn) begin
        wrn_falls++;
        check(oe_lead == WR_SETUP_CYC, "oe_lead", oe_lead, WR_SETUP_CYC);
        check(bus_oe && bus_dout === {8'h00, exp_wbyte}, "bus_dout", bus_dout, {8'h00, exp_wbyte});
      end
      if (wrn && !prev_wrn) begin
        check(wr_run == WR_LOW_CYC, "wrn_low_len", wr_run, WR_LOW_CYC);
        check(bus_oe === 1'b1, "oe_hold", bus_oe, 1'b1);
        wr_run = 0;
      end
      if (!wrn) wr_run++;
      if (bus_oe && wrn) oe_lead++;
      else if (!bus_oe) oe_lead = 0;
      prev_wrn = wrn;
      if (done) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "done_unexpected", rdata, 16'h0000);
        end else begin
          exp_word = exp_q.pop_front();
          check(rdata === exp_word, "rdata", rdata, exp_word);
        end
        check(busy === 1'b0, "busy_at_done", busy, 1'b0);
        check(!mdl_active, "done_before_tx_empty", mdl_active, 1'b0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic r, input logic w, input logic s, input logic [7:0] wd);
    @(posedge clk); #1;
    req_read = r; req_write = w; req_status = s; wdata = wd;
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0; req_status = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit expect_busy, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (expect_busy) check(busy === 1'b1, "busy_window", busy, 1'b1);
      if (!expect_busy) check(busy === 1'b0, "status_busy", busy, 1'b0);
    end
    check(got, "done_timeout", n, budget);
    @(posedge clk); #1;
  endtask

  int n, k, op, f0;

  initial begin
    idle(3);
    @(negedge clk);
    check(rdn === 1'b1 && wrn === 1'b1 && bus_oe === 1'b0 && done === 1'b0 && busy === 1'b0,
          "reset_strobes", {rdn, wrn, bus_oe, done, busy}, 5'b11000);
    check(rdata === 16'h0000 && bus_dout === 16'h0000, "reset_data", {rdata, bus_dout}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(4);

    // status: data_ready=1, tbre=0, tsre=1
    data_ready = 1'b1; tbre_cfg = 1'b0; tsre_cfg = 1'b1;
    idle(4);
    exp_q.push_back(16'h0002);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    wait_done(5, 1'b0, n);
    check(n == 1, "status_latency", n, 1);
    tbre_cfg = 1'b1;

    // plain read, upper bus byte must be dropped
    idle(4);
    bus_din = 16'hAB41;
    exp_q.push_back(16'h0041);
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    wait_done(50, 1'b1, n);

    // read waiting on data_ready
    data_ready = 1'b0;
    idle(4);
    bus_din = 16'h0077;
    exp_q.push_back(16'h0077);
    pulse(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (10) begin
      @(negedge clk);
      check(rdn === 1'b1, "rdn_early", rdn, 1'b1);
    end
    @(posedge clk); #1;
    data_ready = 1'b1;
    wait_done(50, 1'b1, n);
    check(n == SYNC_STAGES + RD_LOW_CYC + 2, "read_wait_latency", n, SYNC_STAGES + RD_LOW_CYC + 2);
    data_ready = 1'b0;

    // write with slow transmitter drain
    exp_wbyte = 8'h5A; tbre_lo = 5; tsre_lo = 8;
    exp_q.push_back(16'h0000);
    pulse(1'b0, 1'b1, 1'b0, 8'h5A);
    wait_done(200, 1'b1, n);

    // collision: read beats write; write while busy is dropped
    idle(4);
    bus_din = 16'h1234;
    exp_q.push_back(16'h0034);
    f0 = wrn_falls;
    pulse(1'b1, 1'b1, 1'b0, 8'hC3);
    idle(2);
    pulse(1'b0, 1'b1, 1'b0, 8'h99);
    idle(1);
    data_ready = 1'b1;
    wait_done(50, 1'b1, n);
    data_ready = 1'b0;
    idle(10);
    check(wrn_falls == f0, "collision_no_write", wrn_falls, f0);
    check(busy === 1'b0, "collision_idle", busy, 1'b0);

    // reset in the middle of the wrn pulse
    exp_wbyte = 8'hE7;
    pulse(1'b0, 1'b1, 1'b0, 8'hE7);
    n = 0;
    while (wrn !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(wrn === 1'b0, "reset_reach_wrlow", wrn, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check(wrn === 1'b1 && rdn === 1'b1 && bus_oe === 1'b0 && busy === 1'b0 && bus_dout === 16'h0000,
          "reset_abort", {wrn, rdn, bus_oe, busy}, 4'b1100);
    idle(2);
    rst = 1'b1;
    idle(4);
    exp_q.push_back(16'h0001);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    wait_done(5, 1'b0, n);
    check(n == 1, "post_reset_idle", n, 1);

    // randomized mix checked against the reference rules
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        data_ready = 1'b0;
        idle(4);
        bus_din = 16'($urandom);
        exp_q.push_back({8'h00, bus_din[7:0]});
        k = $urandom_range(0, 6);
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (k) begin
          @(negedge clk);
          check(rdn === 1'b1, "rand_rdn_early", rdn, 1'b1);
        end
        @(posedge clk); #1;
        data_ready = 1'b1;
        wait_done(60, 1'b1, n);
        data_ready = 1'b0;
      end else if (op == 1) begin
        exp_wbyte = 8'($urandom);
        tbre_lo = $urandom_range(2, 10);
        tsre_lo = $urandom_range(2, 10);
        exp_q.push_back(16'h0000);
        pulse(1'b0, 1'b1, 1'b0, exp_wbyte);
        wait_done(200, 1'b1, n);
      end else begin
        data_ready = 1'($urandom_range(0, 1));
        tbre_cfg   = 1'($urandom_range(0, 1));
        tsre_cfg   = 1'($urandom_range(0, 1));
        idle(4);
        exp_q.push_back({14'b0, data_ready, tbre_cfg & tsre_cfg});
        pulse(1'b0, 1'b0, 1'b1, 8'h00);
        wait_done(5, 1'b0, n);
        check(n == 1, "rand_status_latency", n, 1);
        data_ready = 1'b0; tbre_cfg = 1'b1; tsre_cfg = 1'b1;
        idle(4);
      end
    end

    idle(20);
    check(exp_q.size() == 0, "scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Serial-port engine for the ThinPad CPLD UART, directly downstream of the memory module. The memory module decodes the UART data address (0xBF00) and status address (0xBF01) and issues one-cycle read/write requests to this block. This block owns rdn/wrn, the UART's share of the ram1 data bus, and the tbre/tsre/data_ready handshake. It asserts a stall while a transfer is in flight so the pipeline holds (feeds the noStop path).

Parameters:
RD_LOW_CYC, 2, cycles rdn is held low before read data is sampled (1..15)
WR_SETUP_CYC, 1, cycles data is driven before wrn falls (1..15)
WR_LOW_CYC, 2, cycles wrn is held low (1..15)
SYNC_STAGES, 2, synchroniser depth for data_ready/tbre/tsre (2..3)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
req_read  in  1  one-cycle pulse: read one byte from UART
req_write  in  1  one-cycle pulse: write wdata to UART
req_status  in  1  one-cycle pulse: return status word, no bus activity
wdata  in  8  byte to transmit, sampled on the req_write cycle
rdata  out  16  result: {8'h00, byte} for a read; {14'b0, data_ready_s, tx_ready} for status
done  out  1  one-cycle pulse, rdata valid
busy  out  1  high from the accept cycle until done; the memory module stalls on it
bus_din  in  16  ram1 data bus as seen at the pad
bus_dout  out  16  value to drive on ram1 data bus, {8'h00, byte}
bus_oe  out  1  top-level tristate enable for bus_dout
rdn  out  1  UART read strobe, active-low
wrn  out  1  UART write strobe, active-low
data_ready  in  1  async: receive byte available
tbre  in  1  async: transmit buffer empty
tsre  in  1  async: transmit shift register empty

Behaviour:
- Reset (rst=0, async): state=IDLE, rdn=1, wrn=1, bus_oe=0, bus_dout=0, rdata=0, done=0, busy=0, synchronisers=0, counter=0.
- data_ready, tbre and tsre each pass through SYNC_STAGES flops. Suffix _s = synchronised value. tx_ready = tbre_s & tsre_s.
- Request priority when more than one is asserted in the same cycle: read > write > status. Requests that arrive while busy=1 are ignored. The memory module never issues them.
- IDLE:
  - req_status: rdata={14'b0,data_ready_s,tx_ready}, done=1 on the next cycle. busy is never asserted.
  - req_read: busy=1, go to RD_WAIT.
  - req_write: latch wdata, busy=1, go to WR_WAIT_TX.
- RD_WAIT: wait for data_ready_s=1, then rdn=0, counter=RD_LOW_CYC, go to RD_LOW.
- RD_LOW: count down. On the final cycle sample bus_din[7:0] into rdata, upper byte 0. Next cycle rdn=1, done=1, busy=0, go to IDLE.
- WR_WAIT_TX: wait for tx_ready=1, then bus_oe=1, bus_dout={8'h00,byte}, go to WR_SETUP for WR_SETUP_CYC cycles.
- WR_SETUP: then wrn=0, go to WR_LOW for WR_LOW_CYC cycles.
- WR_LOW: then wrn=1. bus_oe stays high for one more cycle (hold), then bus_oe=0. Go to WR_DRAIN.
- WR_DRAIN: wait for tbre_s=1 then tsre_s=1 (the UART pulls tbre low after wrn rises; wait at least SYNC_STAGES+1 cycles before testing). Then done=1, rdata=0, busy=0, go to IDLE.
- Invariants:
  - rdn and wrn are never low together.
  - bus_oe=0 whenever rdn=0.
  - All strobes are registered, with no combinational path from inputs.
- No timeout; a hung UART keeps busy high. Reset aborts any state: strobes return high and the bus is released immediately.
- done is exactly one cycle wide. busy deasserts in the same cycle as done.

Decomposition:
- Shared package uart_defs: state encoding localparams (IDLE, RD_WAIT, RD_LOW, WR_WAIT_TX, WR_SETUP, WR_LOW, WR_HOLD, WR_DRAIN), UART_DATA_ADDR=16'hBF00, UART_STAT_ADDR=16'hBF01, status bit positions (0 = tx_ready, 1 = data_ready).
- One sub-module, sync_bit: parameterised-depth synchroniser with async active-low reset. Instantiated three times.

Test Plan:
- Reset mid-write: assert rst=0 during WR_LOW -> wrn=1, bus_oe=0, busy=0 within the same cycle. After release, state=IDLE.
- Read: data_ready=1 held, req_read pulse, bus_din=16'h0041 -> rdn low for exactly 2 cycles, done pulse, rdata=16'h0041, busy high for the whole window.
- Read waits: req_read with data_ready=0 for 10 cycles, then 1 -> rdn stays 1 until data_ready_s rises. Total latency = 10+SYNC_STAGES+RD_LOW_CYC+1.
- Write: tbre=tsre=1, req_write wdata=8'h5A -> bus_oe high 1 cycle before wrn falls, wrn low 2 cycles, bus_dout=16'h005A. Model drops tbre for 5 cycles, then tsre for 8 cycles -> done only after both return high.
- Status: data_ready=1, tbre=0, tsre=1, req_status -> done next cycle, rdata=16'h0002, rdn=wrn=1, bus_oe=0 throughout.
- Collision: req_read and req_write in the same cycle, then req_write while busy -> only the read executes, the second write is ignored, and no wrn pulse occurs.
